// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding and
// performance counter width.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LD_WAIT   = 2'd1,
        EXEC_RUN  = 2'd2,
        EXEC_HOLD = 2'd3
    } ctrl_state_t;

    localparam int STALL_CNT_W = 16;

    function automatic logic is_busy(input ctrl_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the IF/ID/EX pipeline: load-use waits, multi-cycle
// EX operations with MEM back-pressure, deferred branch flushes and a watchdog.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit debug_param    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rs1_rs2_valid,
    input  logic                   exec_start,
    input  logic                   exec_done,
    input  logic                   exec_accept,
    input  logic                   branch_flush,
    output logic                   stall_pipe,
    output logic                   bubble_mem,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   timeout_err
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t     state;
    ctrl_state_t     next_state;
    logic            pending_flush;
    logic            next_pending;
    logic [WD_W-1:0] watchdog;
    logic            wd_expire;

    assign ctrl_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending_flush <= 1'b0;
            watchdog      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= next_state;
            pending_flush <= next_pending;
            if (next_state == IDLE) begin
                watchdog <= '0;
            end else if (is_busy(state)) begin
                watchdog <= watchdog + 1'b1;
            end
            if (wd_expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Mealy outputs; a watchdog expiry overrides whatever the state would do.
    always_comb begin
        next_state   = state;
        next_pending = pending_flush;
        stall_pipe   = 1'b0;
        bubble_mem   = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        wd_expire    = !rst && is_busy(state) && (watchdog == WD_LAST);

        if (rst) begin
            next_state   = IDLE;
            next_pending = 1'b0;
        end else if (wd_expire) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            bubble_mem   = 1'b1;
            next_state   = IDLE;
            next_pending = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_flush) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (!rs1_rs2_valid) begin
                        stall_pipe = 1'b1;
                        bubble_mem = 1'b1;
                        next_state = LD_WAIT;
                    end else if (exec_start) begin
                        if (exec_done && !exec_accept) begin
                            stall_pipe = 1'b1;
                            next_state = EXEC_HOLD;
                        end else if (!exec_done) begin
                            stall_pipe = 1'b1;
                            bubble_mem = 1'b1;
                            next_state = EXEC_RUN;
                        end
                    end
                end
                LD_WAIT: begin
                    if (branch_flush) begin
                        flush_id   = 1'b1;
                        flush_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        next_state = IDLE;
                    end else if (!rs1_rs2_valid) begin
                        stall_pipe = 1'b1;
                        bubble_mem = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                // A flush arriving mid-operation is remembered and applied on completion.
                EXEC_RUN: begin
                    next_pending = pending_flush | branch_flush;
                    if (exec_done && exec_accept) begin
                        flush_id     = next_pending;
                        flush_ex     = next_pending;
                        next_pending = 1'b0;
                        next_state   = IDLE;
                    end else begin
                        stall_pipe = 1'b1;
                        bubble_mem = 1'b1;
                        if (exec_done) begin
                            next_state = EXEC_HOLD;
                        end
                    end
                end
                EXEC_HOLD: begin
                    next_pending = pending_flush | branch_flush;
                    if (exec_accept) begin
                        flush_id     = next_pending;
                        flush_ex     = next_pending;
                        next_pending = 1'b0;
                        next_state   = IDLE;
                    end else begin
                        stall_pipe = 1'b1;
                    end
                end
                default: begin
                    next_state   = IDLE;
                    next_pending = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .clear  (rst),
        .enable (stall_pipe),
        .count  (stall_cycles)
    );

`ifndef SYNTHESIS
    generate
        if (debug_param) begin : g_trace
            always @(negedge clk) begin
                if (!rst && (next_state != state)) begin
                    $write("[pipeline_stall_ctrl] %0t state %0d -> %0d\n",
                           $time, state, next_state);
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// cycle by cycle against a behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs1_rs2_valid;
    logic        exec_start;
    logic        exec_done;
    logic        exec_accept;
    logic        branch_flush;
    logic        stall_pipe;
    logic        bubble_mem;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic        timeout_err;

    logic        sc_clear;
    logic        sc_en;
    logic [3:0]  sc_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .debug_param    (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_rs2_valid (rs1_rs2_valid),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .exec_accept   (exec_accept),
        .branch_flush  (branch_flush),
        .stall_pipe    (stall_pipe),
        .bubble_mem    (bubble_mem),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .ctrl_state    (ctrl_state),
        .stall_cycles  (stall_cycles),
        .timeout_err   (timeout_err)
    );

    sat_counter #(
        .WIDTH (4)
    ) u_sat (
        .clk    (clk),
        .clear  (sc_clear),
        .enable (sc_en),
        .count  (sc_count)
    );

    int n_vectors = 0;
    int n_fails   = 0;

    // Reference model: mode uses the architectural numbering (0 idle, 1 load
    // wait, 2 op running, 3 result waiting for MEM).
    int m_mode   = 0;
    int m_age    = 0;
    int m_stalls = 0;
    bit m_pend   = 1'b0;
    bit m_err    = 1'b0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict, compare, then advance the model.
    task automatic applyStimulus(input bit r, input bit v, input bit s,
                                 input bit d, input bit a, input bit f);
        bit e_stall, e_bub, e_flush, timed_out, finish, pend;
        int nx_mode;
        bit nx_pend;
        @(negedge clk);
        rst = r; rs1_rs2_valid = v; exec_start = s;
        exec_done = d; exec_accept = a; branch_flush = f;
        #1;
        e_stall = 0; e_bub = 0; e_flush = 0; timed_out = 0;
        nx_mode = m_mode; nx_pend = m_pend;
        if (r) begin
            nx_mode = 0; nx_pend = 0;
        end else if (m_mode != 0 && m_age == TIMEOUT - 1) begin
            timed_out = 1; e_flush = 1; e_bub = 1; nx_mode = 0; nx_pend = 0;
        end else if (m_mode == 0) begin
            if (f) e_flush = 1;
            else if (!v) begin e_stall = 1; e_bub = 1; nx_mode = 1; end
            else if (s && !(d && a)) begin
                e_stall = 1; e_bub = !d; nx_mode = d ? 3 : 2;
            end
        end else if (m_mode == 1) begin
            if (f) begin e_flush = 1; e_bub = 1; nx_mode = 0; end
            else if (!v) begin e_stall = 1; e_bub = 1; end
            else nx_mode = 0;
        end else begin
            finish = (m_mode == 2) ? (d && a) : a;
            pend   = m_pend | f;
            if (finish) begin
                e_flush = pend; nx_mode = 0; nx_pend = 0;
            end else begin
                e_stall = 1; e_bub = (m_mode == 2);
                nx_mode = (m_mode == 2 && d) ? 3 : m_mode;
                nx_pend = pend;
            end
        end
        checkOutput("stall_pipe",   16'(stall_pipe),  16'(e_stall));
        checkOutput("bubble_mem",   16'(bubble_mem),  16'(e_bub));
        checkOutput("flush_id",     16'(flush_id),    16'(e_flush));
        checkOutput("flush_ex",     16'(flush_ex),    16'(e_flush));
        checkOutput("ctrl_state",   16'(ctrl_state),  16'(m_mode));
        checkOutput("stall_cycles", stall_cycles,     16'(m_stalls));
        checkOutput("timeout_err",  16'(timeout_err), 16'(m_err));
        if (r) begin
            m_stalls = 0; m_err = 0; m_age = 0;
        end else begin
            if (e_stall && m_stalls < 65535) m_stalls++;
            if (timed_out) m_err = 1;
            m_age = (nx_mode == 0) ? 0 : ((m_mode != 0) ? m_age + 1 : 0);
        end
        m_mode = nx_mode;
        m_pend = nx_pend;
    endtask

    task automatic idleStep();
        applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    task automatic resetStep();
        applyStimulus(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; rs1_rs2_valid = 1; exec_start = 0; exec_done = 0;
        exec_accept = 0; branch_flush = 0; sc_clear = 1; sc_en = 0;

        resetStep();
        resetStep();
        idleStep();

        // Load-use: three cycles of missing operands.
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("ld_use_total", stall_cycles, 16'd3);
        idleStep();

        // Multi-cycle op completing with accept at cycle 5.
        resetStep();
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (4) idleStep();
        applyStimulus(0, 1, 0, 1, 1, 0);
        checkOutput("mc_stall_low", 16'(stall_pipe), 16'd0);
        checkOutput("mc_total", stall_cycles, 16'd5);
        idleStep();

        // Back-pressure from MEM.
        resetStep();
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (3) idleStep();
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("bp_state_hold", 16'(ctrl_state), 16'd3);
        checkOutput("bp_bubble_hold", 16'(bubble_mem), 16'd0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("bp_stall_drop", 16'(stall_pipe), 16'd0);
        idleStep();

        // Branch flush during an op is deferred to completion.
        resetStep();
        applyStimulus(0, 1, 1, 0, 0, 0);
        idleStep();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("df_no_early_flush", 16'(flush_id), 16'd0);
        repeat (3) idleStep();
        applyStimulus(0, 1, 0, 1, 1, 0);
        checkOutput("df_flush_at_done", 16'(flush_id), 16'd1);
        idleStep();
        checkOutput("df_flush_cleared", 16'(flush_ex), 16'd0);

        // Watchdog: op never completes.
        resetStep();
        applyStimulus(0, 1, 1, 0, 0, 0);
        repeat (7) idleStep();
        idleStep();
        checkOutput("wd_flush", 16'(flush_ex), 16'd1);
        idleStep();
        checkOutput("wd_err_set", 16'(timeout_err), 16'd1);
        checkOutput("wd_idle", 16'(ctrl_state), 16'd0);
        repeat (3) idleStep();
        checkOutput("wd_err_sticky", 16'(timeout_err), 16'd1);
        resetStep();
        idleStep();
        checkOutput("wd_err_cleared", 16'(timeout_err), 16'd0);

        // Reset in the middle of a held result.
        resetStep();
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 1);
        checkOutput("rst_outputs_zero", 16'({stall_pipe, bubble_mem, flush_id, flush_ex}), 16'd0);
        idleStep();
        checkOutput("rst_state", 16'(ctrl_state), 16'd0);
        checkOutput("rst_stall_cycles", stall_cycles, 16'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 10);
        end

        // Saturation of a narrow counter instance.
        @(negedge clk);
        sc_clear = 1; sc_en = 1;
        @(negedge clk);
        sc_clear = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            checkOutput("sat_count", 16'(sc_count), 16'((n < 15) ? n : 15));
            @(negedge clk);
        end
        sc_en = 0;
        #1;
        checkOutput("sat_hold", 16'(sc_count), 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fails);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: consecutive non-IDLE cycles before a forced return to IDLE.
REQ-002 Parameter debug_param, default 1: 1 enables simulation-only $write trace of state transitions on negedge clk.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rs1_rs2_valid  input  1  operands for EX available; low means load-use wait from the forwarding unit.
REQ-006 exec_start  input  1  multi-cycle operation issued in EX this cycle.
REQ-007 exec_done  input  1  multi-cycle result ready.
REQ-008 exec_accept  input  1  MEM stage accepts the EX result this cycle.
REQ-009 branch_flush  input  1  redirect request; younger instructions in ID/EX to be killed.
REQ-010 stall_pipe  output  1  hold IF, ID and EX pipeline registers.
REQ-011 bubble_mem  output  1  write a NOP into the EX/MEM register.
REQ-012 flush_id  output  1  kill the instruction in ID.
REQ-013 flush_ex  output  1  kill the instruction in EX.
REQ-014 ctrl_state  output  2  current state: IDLE=0, LD_WAIT=1, EXEC_RUN=2, EXEC_HOLD=3.
REQ-015 stall_cycles  output  16  saturating count of cycles with stall_pipe=1.
REQ-016 timeout_err  output  1  sticky; set on watchdog expiry.

Function
REQ-017 All outputs SHALL be combinational from registered state plus the current inputs (Mealy), with zero-cycle latency from input to stall.
REQ-018 IDLE: branch_flush=1 SHALL assert flush_id and flush_ex for that cycle, with no stall, and state stays IDLE; flush takes priority over all other inputs.
REQ-019 IDLE, no flush, rs1_rs2_valid=0: stall_pipe=1, bubble_mem=1, next state LD_WAIT.
REQ-020 IDLE, no flush, rs1_rs2_valid=1, exec_start=1: if exec_done and exec_accept are both 1, no stall and state stays IDLE; if exec_done=1 and exec_accept=0, stall_pipe=1 and next state EXEC_HOLD; otherwise stall_pipe=1, bubble_mem=1 and next state EXEC_RUN.
REQ-021 LD_WAIT: stall_pipe=1 and bubble_mem=1 while rs1_rs2_valid=0; when rs1_rs2_valid=1, both deassert in the same cycle and next state is IDLE.
REQ-022 LD_WAIT with branch_flush=1: flush_id=1, flush_ex=1, stall_pipe=0, bubble_mem=1, next state IDLE.
REQ-023 EXEC_RUN: stall_pipe=1 and bubble_mem=1; exec_done with exec_accept deasserts both that cycle and goes to IDLE; exec_done without exec_accept goes to EXEC_HOLD.
REQ-024 EXEC_HOLD: stall_pipe=1 and bubble_mem=0 (the result is presented to MEM); exec_accept=1 deasserts stall that cycle and goes to IDLE.
REQ-025 branch_flush in EXEC_RUN or EXEC_HOLD SHALL set a pending_flush register and SHALL NOT abort the operation.
REQ-026 pending_flush SHALL drive flush_id and flush_ex in the completion cycle (the transition to IDLE) and then clear.
REQ-027 A watchdog counter SHALL clear on entry to IDLE and increment each non-IDLE cycle.
REQ-028 When the watchdog equals TIMEOUT_CYCLES-1 in a non-IDLE state, the block SHALL force next state to IDLE, set timeout_err, flush ID/EX that cycle and clear pending_flush.
REQ-029 stall_cycles SHALL increment on every cycle with stall_pipe=1 and hold at 16'hFFFF.
REQ-030 exec_done or exec_accept in IDLE without exec_start SHALL be ignored.

Reset
REQ-031 rst=1 at a posedge SHALL set the state to IDLE and clear pending_flush, the watchdog, stall_cycles and timeout_err, including mid-operation in any state.
REQ-032 While rst=1, stall_pipe, bubble_mem, flush_id and flush_ex SHALL be 0.

Structure
REQ-033 The state encoding and the stall_cycles width (16) SHALL live in the shared pipeline control package/header; TIMEOUT_CYCLES remains a module parameter.
REQ-034 The saturating performance counter SHALL be one sub-module, sat_counter (parameterised width, enable, sync clear).
REQ-035 The FSM, the watchdog and pending_flush SHALL reside in pipeline_stall_ctrl; the forwarding/hazard logic SHALL stay outside this block.

Verification
REQ-036 Load-use: rs1_rs2_valid low for 3 cycles from IDLE -> stall_pipe=1 and bubble_mem=1 for exactly 3 cycles, ctrl_state 1 then 0, stall_cycles=3.
REQ-037 Multi-cycle op: exec_start at cycle 0, exec_done with exec_accept at cycle 5 -> stall_pipe high cycles 0-4, low at cycle 5, stall_cycles=5.
REQ-038 Back-pressure: exec_done at cycle 4 with exec_accept=0 until cycle 7 -> ctrl_state=3 during cycles 5-7, bubble_mem=0 in EXEC_HOLD, stall drops at cycle 7.
REQ-039 Deferred flush: branch_flush pulse in EXEC_RUN at cycle 2, completion at cycle 6 -> flush_id=flush_ex=1 only at cycle 6.
REQ-040 Watchdog: TIMEOUT_CYCLES=8, exec_start and never exec_done -> forced IDLE after 8 cycles with flushes, timeout_err=1 until rst.
REQ-041 Reset mid-op: rst pulse in EXEC_HOLD -> next cycle ctrl_state=0, stall_cycles=0, timeout_err=0, all control outputs 0.
